// File: rtl/uart_mem_master.sv
// UART command bridge: host frames over 8N1 serial become single 32-bit bus transactions.
// Parser: IDLE wait cmd | ADDR collect A0..A3 | DATA collect D0..D3 | BUS hold request | RESP hand bytes to TX
module uart_mem_master #(
  parameter int CLK_DIV = 104,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        mem_m_valid,
  output logic [31:0] mem_m_addr,
  output logic [31:0] mem_m_wdata,
  output logic [3:0]  mem_m_wstrb,
  input  logic        mem_m_ready,
  input  logic [31:0] mem_m_rdata,
  output logic        busy
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
  localparam logic [TO_W-1:0] TO_M1 = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_BUS, P_RESP} p_state_t;

  // ---------------- receiver ----------------
  logic [1:0]  rx_sync_q;
  logic        rx_prev_q;
  logic        rx_s;
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_done, rx_ferr;

  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], ser_rx};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else if (rx_s) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = DIV_M1;
          rx_bit_d   = 3'd0;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_cnt_d   = DIV_M1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_state_d = RX_IDLE;
          rx_done    = rx_s;
          rx_ferr    = !rx_s;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- parser / bus master ----------------
  p_state_t         p_state_q, p_state_d;
  logic [1:0]       p_idx_q, p_idx_d;
  logic             is_wr_q, is_wr_d;
  logic [29:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      resp_q, resp_d;
  logic [2:0]       resp_left_q, resp_left_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             tx_wr, tx_acc;
  logic             hold_valid_q, hold_valid_d;

  assign tx_acc      = tx_wr && !hold_valid_q;
  assign mem_m_valid = (p_state_q == P_BUS);
  assign mem_m_addr  = {addr_q, 2'b00};
  assign mem_m_wdata = wdata_q;
  assign mem_m_wstrb = (p_state_q == P_BUS && is_wr_q) ? 4'hF : 4'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_state_q   <= P_IDLE;
      p_idx_q     <= '0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_q      <= '0;
      resp_left_q <= '0;
      to_cnt_q    <= '0;
    end else begin
      p_state_q   <= p_state_d;
      p_idx_q     <= p_idx_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_q      <= resp_d;
      resp_left_q <= resp_left_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  always_comb begin
    p_state_d   = p_state_q;
    p_idx_d     = p_idx_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_d      = resp_q;
    resp_left_d = resp_left_q;
    to_cnt_d    = to_cnt_q;
    tx_wr       = 1'b0;
    case (p_state_q)
      P_IDLE: begin
        if (rx_done) begin
          p_idx_d  = 2'd0;
          to_cnt_d = TO_M1;
          if (rx_shift_q == 8'h57 || rx_shift_q == 8'h52) begin
            p_state_d = P_ADDR;
            is_wr_d   = (rx_shift_q == 8'h57);
          end else begin
            p_state_d   = P_RESP;
            resp_d      = 32'h0000_0045;
            resp_left_d = 3'd1;
          end
        end
      end
      P_ADDR, P_DATA: begin
        if (rx_ferr) begin
          p_state_d = P_IDLE;
        end else if (rx_done) begin
          to_cnt_d = TO_M1;
          p_idx_d  = p_idx_q + 2'd1;
          // Shifting in from the top leaves A0[7:2] in the low bits once A3 lands.
          if (p_state_q == P_ADDR) addr_d  = {rx_shift_q, addr_q[29:8]};
          else                     wdata_d = {rx_shift_q, wdata_q[31:8]};
          if (p_idx_q == 2'd3) begin
            if (p_state_q == P_ADDR && is_wr_q) p_state_d = P_DATA;
            else                                p_state_d = P_BUS;
          end
        end else if (to_cnt_q == '0) begin
          p_state_d = P_IDLE;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
        end
      end
      P_BUS: begin
        if (mem_m_ready) begin
          p_state_d   = P_RESP;
          resp_d      = is_wr_q ? 32'h0000_004B : mem_m_rdata;
          resp_left_d = is_wr_q ? 3'd1 : 3'd4;
        end
      end
      P_RESP: begin
        tx_wr = 1'b1;
        if (tx_acc) begin
          resp_d      = {8'h00, resp_q[31:8]};
          resp_left_d = resp_left_q - 3'd1;
          if (resp_left_q == 3'd1) p_state_d = P_IDLE;
        end
      end
      default: p_state_d = P_IDLE;
    endcase
  end

  // ---------------- transmitter ----------------
  logic [9:0]  tx_shift_q, tx_shift_d;
  logic [3:0]  tx_bits_q, tx_bits_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic        tx_active_q, tx_active_d;
  logic [7:0]  hold_q, hold_d;
  logic        tx_last, tx_free;

  assign ser_tx = tx_shift_q[0];
  assign busy   = (p_state_q != P_IDLE) || tx_active_q || hold_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_shift_q   <= '1;
      tx_bits_q    <= '0;
      tx_cnt_q     <= '0;
      tx_active_q  <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      tx_shift_q   <= tx_shift_d;
      tx_bits_q    <= tx_bits_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_active_q  <= tx_active_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  always_comb begin
    tx_shift_d   = tx_shift_q;
    tx_bits_d    = tx_bits_q;
    tx_cnt_d     = tx_cnt_q;
    tx_active_d  = tx_active_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    tx_last      = tx_active_q && tx_cnt_q == 16'd0 && tx_bits_q == 4'd0;
    tx_free      = !tx_active_q || tx_last;
    if (tx_active_q && !tx_last) begin
      if (tx_cnt_q == 16'd0) begin
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bits_d  = tx_bits_q - 4'd1;
        tx_cnt_d   = DIV_M1;
      end else begin
        tx_cnt_d = tx_cnt_q - 16'd1;
      end
    end
    // The engine reloads on the stop bit's final cycle so queued bytes leave back-to-back.
    if (tx_free) begin
      if (hold_valid_q || tx_acc) begin
        tx_shift_d   = {1'b1, (hold_valid_q ? hold_q : resp_q[7:0]), 1'b0};
        tx_bits_d    = 4'd9;
        tx_cnt_d     = DIV_M1;
        tx_active_d  = 1'b1;
        hold_valid_d = 1'b0;
      end else begin
        tx_active_d = 1'b0;
      end
    end else if (tx_acc) begin
      hold_d       = resp_q[7:0];
      hold_valid_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_mem_master.sv
// Randomized scoreboard bench: frame-level host model predicts bus requests and TX bytes.
module tb_uart_mem_master;
  localparam int DIV = 16;
  localparam int TO  = 500;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ser_rx = 1'b1;
  logic        ser_tx;
  logic        mem_m_valid;
  logic [31:0] mem_m_addr, mem_m_wdata, mem_m_rdata;
  logic [3:0]  mem_m_wstrb;
  logic        mem_m_ready;
  logic        busy;

  uart_mem_master #(.CLK_DIV(DIV), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ser_rx(ser_rx), .ser_tx(ser_tx),
    .mem_m_valid(mem_m_valid), .mem_m_addr(mem_m_addr), .mem_m_wdata(mem_m_wdata),
    .mem_m_wstrb(mem_m_wstrb), .mem_m_ready(mem_m_ready), .mem_m_rdata(mem_m_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: ready after slv_delay wait cycles; delay 0 means ready the cycle valid rises.
  int          slv_delay = 0;
  int          slv_cnt = 0;
  logic [31:0] slv_rdata = 32'h0;
  always @(posedge clk) slv_cnt <= (mem_m_valid && !mem_m_ready) ? slv_cnt + 1 : 0;
  assign mem_m_ready = mem_m_valid && (slv_cnt == slv_delay);
  assign mem_m_rdata = slv_rdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    bit          chk_wdata;
  } bus_t;
  typedef struct {
    logic [7:0] b;
    int         mode;   // 0 free, 1 first after bus completion, 2 back-to-back with previous
    bit         last;
  } txe_t;

  bus_t bus_q[$];
  txe_t tx_q[$];
  int n_checks = 0, n_fail = 0;
  int n_bus_seen = 0, n_bus_exp = 0, n_tx_seen = 0, n_tx_exp = 0;
  int last_ready_cyc = -100000;
  bit tx_abort = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_neg(int n);
    repeat (n) begin
      @(negedge clk);
      if (reset) tx_abort = 1'b1;
    end
  endtask

  // Bus monitor
  initial begin
    int vcnt;
    bus_t cur;
    logic [31:0] a0, w0;
    logic [3:0] s0;
    bit stable;
    vcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        vcnt = 0;
        continue;
      end
      if (mem_m_valid) begin
        if (vcnt == 0) begin
          a0 = mem_m_addr; w0 = mem_m_wdata; s0 = mem_m_wstrb; stable = 1'b1;
        end else if (mem_m_addr !== a0 || mem_m_wdata !== w0 || mem_m_wstrb !== s0) begin
          stable = 1'b0;
        end
        vcnt++;
        if (mem_m_ready) begin
          n_bus_seen++;
          if (bus_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL bus_unexpected: got request addr %0h wstrb %0h, expected none", mem_m_addr, mem_m_wstrb);
          end else begin
            cur = bus_q.pop_front();
            check("bus_addr", mem_m_addr, cur.addr);
            check("bus_wstrb", mem_m_wstrb, cur.wstrb);
            if (cur.chk_wdata) check("bus_wdata", mem_m_wdata, cur.wdata);
            check("bus_valid_len", vcnt, cur.delay + 1);
            check("bus_stable", stable, 1);
          end
          last_ready_cyc = cyc;
          vcnt = 0;
        end
      end
    end
  end

  // TX monitor
  initial begin
    int s, prev_s;
    logic [7:0] b;
    logic stb, sbit;
    txe_t e;
    prev_s = -100000;
    forever begin
      @(negedge clk);
      if (reset || ser_tx !== 1'b0) continue;
      s = cyc;
      tx_abort = 1'b0;
      wait_neg(DIV / 2);
      stb = ser_tx;
      for (int k = 0; k < 8; k++) begin
        wait_neg(DIV);
        b[k] = ser_tx;
      end
      wait_neg(DIV);
      sbit = ser_tx;
      if (tx_abort) continue;
      n_tx_seen++;
      check("tx_start_bit", stb, 0);
      check("tx_stop_bit", sbit, 1);
      if (tx_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL tx_unexpected: got byte %0h, expected none", b);
      end else begin
        e = tx_q.pop_front();
        check("tx_byte", b, e.b);
        if (e.mode == 1) check("tx_first_start_cycle", s, last_ready_cyc + 2);
        else if (e.mode == 2) check("tx_back_to_back", s, prev_s + 10 * DIV);
        if (e.last) begin
          wait_neg(DIV / 2 - 1);
          if (!tx_abort) check("busy_before_stop_end", busy, 1);
          wait_neg(1);
          if (!tx_abort) check("busy_after_stop_end", busy, 0);
        end
      end
      prev_s = s;
    end
  end

  task automatic send_byte(logic [7:0] b, logic stop = 1'b1);
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      ser_rx = b[k];
      repeat (DIV) @(negedge clk);
    end
    ser_rx = stop;
    repeat (DIV) @(negedge clk);
    ser_rx = 1'b1;
  endtask

  task automatic do_write(logic [31:0] a, logic [31:0] d, int dly);
    slv_delay = dly;
    bus_q.push_back('{addr: a & 32'hFFFF_FFFC, wdata: d, wstrb: 4'hF, delay: dly, chk_wdata: 1'b1});
    tx_q.push_back('{b: 8'h4B, mode: 1, last: 1'b1});
    n_bus_exp++; n_tx_exp++;
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(8'((a >> (8 * i)) & 32'hFF));
    for (int i = 0; i < 4; i++) send_byte(8'((d >> (8 * i)) & 32'hFF));
  endtask

  task automatic do_read(logic [31:0] a, logic [31:0] rd, int dly);
    slv_delay = dly;
    slv_rdata = rd;
    bus_q.push_back('{addr: a & 32'hFFFF_FFFC, wdata: 32'h0, wstrb: 4'h0, delay: dly, chk_wdata: 1'b0});
    for (int i = 0; i < 4; i++)
      tx_q.push_back('{b: 8'((rd >> (8 * i)) & 32'hFF), mode: (i == 0) ? 1 : 2, last: (i == 3)});
    n_bus_exp++; n_tx_exp += 4;
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'((a >> (8 * i)) & 32'hFF));
  endtask

  task automatic do_bad(logic [7:0] cmd);
    tx_q.push_back('{b: 8'h45, mode: 0, last: 1'b1});
    n_tx_exp++;
    send_byte(cmd);
  endtask

  task automatic wait_idle(string name);
    int t;
    t = 0;
    while ((bus_q.size() != 0 || tx_q.size() != 0 || busy) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 6000) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got %0d bus / %0d tx pending, expected 0", name, bus_q.size(), tx_q.size());
      bus_q.delete();
      tx_q.delete();
    end
    repeat (DIV) @(negedge clk);
  endtask

  task automatic check_counts(string name);
    check({name, "_bus_count"}, n_bus_seen, n_bus_exp);
    check({name, "_tx_count"}, n_tx_seen, n_tx_exp);
  endtask

  initial begin
    #(1_500_000);
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit act;
    int kind, t;
    logic [7:0] cmd;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ser_tx", ser_tx, 1);
    check("rst_valid", mem_m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", mem_m_addr, 0);
    check("rst_wdata", mem_m_wdata, 0);
    check("rst_wstrb", mem_m_wstrb, 0);
    reset = 1'b0;
    act = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy || !ser_tx || mem_m_valid) act = 1'b1;
    end
    check("idle_quiet", act, 0);

    do_write(32'h2000_0010, 32'hDEAD_BEEF, 3);
    wait_idle("write");
    do_read(32'h0000_0107, 32'h1234_5678, 0);
    wait_idle("read");
    do_bad(8'hA5);
    wait_idle("badcmd");
    check_counts("directed");

    // Framing error mid-address, then a clean read.
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h11, 1'b0);
    repeat (12 * DIV) @(negedge clk);
    check_counts("framing");
    do_read($urandom, $urandom, $urandom_range(0, 5));
    wait_idle("after_framing");

    // Inter-byte timeout on a partial write.
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (600) @(negedge clk);
    check("timeout_idle_busy", busy, 0);
    do_read($urandom, $urandom, $urandom_range(0, 5));
    wait_idle("after_timeout");
    check_counts("timeout");

    for (int n = 0; n < 10; n++) begin
      kind = $urandom_range(0, 4);
      if (kind < 2) begin
        do_write($urandom, $urandom, $urandom_range(0, 5));
      end else if (kind < 4) begin
        do_read($urandom, $urandom, $urandom_range(0, 5));
      end else begin
        cmd = 8'($urandom_range(0, 255));
        if (cmd == 8'h57 || cmd == 8'h52) cmd = 8'h00;
        do_bad(cmd);
      end
      wait_idle("random");
    end
    check_counts("random");

    // Reset in the middle of the second read-response byte.
    do_read($urandom, $urandom, 1);
    t = 0;
    while (tx_q.size() > 3 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("midreset_first_byte_seen", tx_q.size(), 3);
    repeat (3 * DIV) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_ser_tx", ser_tx, 1);
    check("midreset_busy", busy, 0);
    check("midreset_valid", mem_m_valid, 0);
    n_tx_exp -= tx_q.size();
    tx_q.delete();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    check("post_reset_ser_tx", ser_tx, 1);
    do_read($urandom, $urandom, $urandom_range(0, 5));
    wait_idle("after_reset");
    check_counts("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_mem_master.md
# uart_mem_master

Serial debug/loader bridge: receives command frames on a UART RX line, executes them as single 32-bit transactions as *initiator* on the native memory bus, and returns results on UART TX. It is the bus master counterpart of the memory-mapped UART slave. It sits beside the CPU on a shared bus arbiter so a host PC can peek and poke SoC memory without firmware.

## Interface
- CLK_DIV, 104: clock cycles per UART bit; legal range 8..65535.
- TIMEOUT, 1000000: idle cycles between frame bytes before the parser aborts to IDLE.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ser_rx  in  1  UART receive line, idle high, 8N1, asynchronous to clk.
- ser_tx  out  1  UART transmit line, idle high, 8N1.
- mem_m_valid  out  1  transaction request.
- mem_m_addr  out  32  word address; bits [1:0] always 0.
- mem_m_wdata  out  32  write data.
- mem_m_wstrb  out  4  4'hF for write, 4'h0 for read.
- mem_m_ready  in  1  slave completion.
- mem_m_rdata  in  32  read data, valid when mem_m_ready=1.
- busy  out  1  high from the first accepted command byte until the response's last stop bit ends.

## Operation
- RX: ser_rx passes through a 2-flop synchronizer. A falling edge in RX idle starts a frame. Bit sampling:
  - start bit sampled at CLK_DIV/2 cycles; if high, abort (glitch).
  - data bits, LSB first, sampled every CLK_DIV cycles after the start-bit sample.
  - stop bit sampled one CLK_DIV after the last data bit. If the stop bit is 0 (framing error), drop the byte and force the parser to IDLE.
- TX: start bit, 8 data bits LSB first, stop bit; each bit held exactly CLK_DIV cycles. One-byte holding register.
- Frame format (multi-byte fields little-endian):
  - write: 0x57, A0..A3, D0..D3 -> response 0x4B.
  - read: 0x52, A0..A3 -> response R0..R3 (rdata LSB byte first).
  - any other first byte: response 0x45; parser returns to IDLE.
- Parser states, decided:
  - IDLE: wait for a command byte.
  - ADDR: count 0..3.
  - DATA: count 0..3, write only.
  - BUS: assert the transaction.
  - RESP: send the response byte(s).
  - Return to IDLE after the last response byte is handed to TX.
- Bytes received during BUS or RESP are discarded.
- Inter-byte timeout: in ADDR or DATA, TIMEOUT cycles with no completed byte -> IDLE. No response is sent.
- mem_m_addr = {A3,A2,A1,A0[7:2],2'b00}; the host's low two address bits are ignored.

## Timing
- Reset values:
  - ser_tx=1, mem_m_valid=0, mem_m_addr=0, mem_m_wdata=0, mem_m_wstrb=0, busy=0.
  - RX, TX and parser in idle; all counters 0.
- mem_m_valid rises the cycle after the final frame byte's stop-bit sample.
- While mem_m_valid=1, addr, wdata and wstrb are stable. valid is held until the cycle mem_m_ready=1 and drops on the next edge.
- rdata is captured on the ready cycle. Only one transaction per frame.
- ready arriving in the same cycle valid rises is legal: a 1-cycle transaction.
- No bus timeout: a slave that never asserts ready stalls the block until reset.
- The first TX start bit begins 1 cycle after valid falls. Consecutive response bytes are back-to-back with no idle bits.
- reset mid-operation:
  - all outputs return to reset values immediately, asynchronously.
  - a partial TX byte is truncated; ser_tx goes high.
  - a pending bus request is abandoned.

## Test plan
- CLK_DIV=16, reset at idle -> ser_tx=1, mem_m_valid=0, busy=0; hold 100 cycles, no activity.
- Send 57 10 00 00 20 EF BE AD DE; slave asserts ready after 3 cycles -> exactly one request: addr 0x20000010, wdata 0xDEADBEEF, wstrb F, valid high for 4 cycles. Then TX byte 0x4B and busy falls at end of its stop bit.
- Send 52 07 01 00 00; slave returns rdata 0x12345678 with ready the same cycle valid rises -> addr 0x00000104 (low bits masked). TX bytes 78 56 34 12 back-to-back.
- Send 0xA5 -> TX byte 0x45; no mem_m_valid pulse.
- Framing error: send 52 00 then a byte with stop bit 0 -> no bus transaction, no TX. A following valid read frame executes normally.
- TIMEOUT=500: send 57 00 00 then silence for 600 cycles, then a full read frame -> no write occurs; the read executes. Separately, assert reset mid-read-response -> ser_tx=1 and busy=0 immediately.
